bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that multiplexes MASTER_NUM masters onto a single slave port.
// Define BUS_ARBITER_TIMEOUT_EN to enable the slave-ack watchdog (TIMEOUT_CYCLES).
module bus_arbiter #(
    parameter int MASTER_NUM     = 3,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MASTER_NUM-1:0]            m_req,
    input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_addr,
    input  logic [MASTER_NUM-1:0]            m_we,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_wdata,
    output logic [MASTER_NUM-1:0]            m_gnt,
    output logic [MASTER_NUM-1:0]            m_done,
    output logic                             m_err,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             s_req,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic                             s_we,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    input  logic                             s_ack
);

    localparam int IDX_W = $clog2(MASTER_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      last_grant;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W:0]        cand;
    logic                  pick_vld;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;
    logic                  pick_we;
    logic [MASTER_NUM-1:0] pick_oh;
    logic [MASTER_NUM-1:0] owner_oh;
    logic                  timeout_hit;

    // Walk farthest-first so the requester nearest after last_grant wins the override.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int off = MASTER_NUM; off >= 1; off--) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(MASTER_NUM)) begin
                cand = cand - (IDX_W+1)'(MASTER_NUM);
            end
            if (m_req[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        pick_we    = 1'b0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                pick_we    = m_we[i];
            end
        end
    end

    assign pick_oh  = {{(MASTER_NUM-1){1'b0}}, 1'b1} << pick_idx;
    assign owner_oh = {{(MASTER_NUM-1){1'b0}}, 1'b1} << owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = BUSY;
            BUSY:    if (s_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side request, payload, grant and completion registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IDX_W'(MASTER_NUM - 1);
            owner      <= '0;
            m_gnt      <= '0;
            m_done     <= '0;
            m_rdata    <= '0;
            s_req      <= 1'b0;
            s_addr     <= '0;
            s_we       <= 1'b0;
            s_wdata    <= '0;
        end else begin
            m_done <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner   <= pick_idx;
                        m_gnt   <= pick_oh;
                        s_req   <= 1'b1;
                        s_addr  <= pick_addr;
                        s_we    <= pick_we;
                        s_wdata <= pick_wdata;
                    end
                end
                BUSY: begin
                    if (s_ack) begin
                        m_rdata <= s_rdata;
                        s_req   <= 1'b0;
                        m_done  <= owner_oh;
                    end else if (timeout_hit) begin
                        s_req   <= 1'b0;
                        m_done  <= owner_oh;
                    end
                end
                DONE: begin
                    m_gnt      <= '0;
                    last_grant <= owner;
                end
                default: begin
                    m_gnt <= '0;
                    s_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    // wd_cnt counts completed BUSY cycles without ack; the last allowed one fires the timeout.
    assign timeout_hit = (state == BUSY) && !s_ack &&
                         (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state != BUSY) begin
            wd_cnt <= '0;
        end else if (!s_ack && !timeout_hit) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_err <= 1'b0;
        end else if (state == BUSY) begin
            m_err <= timeout_hit;
        end else if (state == DONE) begin
            m_err <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign m_err              = 1'b0;
`endif

`ifndef SYNTHESIS
    a_onehot_outputs: assert property (@(posedge clk) disable iff (rst)
        $onehot0(m_gnt) && $onehot0(m_done));
`endif

endmodule
